// File: rtl/aes_result_led_pager.sv
// aes_result_led_pager: latches the AES result and pages it byte-by-byte onto 8 LEDs; define PAGER_AUTOSCROLL_EN for timed auto-advance
module aes_result_led_pager #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCROLL_CYCLES = 50000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         result_valid,
    input  logic [127:0] result,
    input  logic         btn_next,
    input  logic         auto_scroll,
    output logic [7:0]   disp_byte,
    output logic [3:0]   disp_idx,
    output logic         have_result
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;
    logic [0:0] state;
    logic s1, s2, db, db_d, step, adv;
    logic [CW-1:0] cnt;
    logic [127:0] stored, src;
    logic [3:0] nidx;
    // button synchronizer, debounce counter and edge register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            db <= 1'b0;
            db_d <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= btn_next;
            s2 <= s1;
            db_d <= db;
            if (s2 == db) cnt <= '0;
            else if (cnt == CMAX) begin
                db <= s2;
                cnt <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
    assign step = db & ~db_d;
`ifdef PAGER_AUTOSCROLL_EN
    localparam int SW = $clog2(SCROLL_CYCLES);
    localparam logic [SW-1:0] SMAX = SW'(SCROLL_CYCLES - 1);
    logic [SW-1:0] scnt;
    logic expire;
    assign expire = (state == SHOW) && auto_scroll && (scnt == SMAX);
    // scroll period counter, restarted by any index change or when scrolling is off
    always_ff @(posedge clk) begin
        if (!rst_n || result_valid || step || !auto_scroll || state != SHOW || expire) scnt <= '0;
        else scnt <= scnt + 1'b1;
    end
    assign adv = step | expire;
`else
    logic unused_auto_scroll;
    assign unused_auto_scroll = auto_scroll;
    assign adv = step;
`endif
    assign nidx = result_valid ? 4'd0 : disp_idx + 4'd1;
    assign src = result_valid ? result : stored;
    // latch on result_valid (wins over a step), otherwise advance the page in SHOW
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            stored <= '0;
            disp_idx <= 4'd0;
            disp_byte <= 8'd0;
        end else if (result_valid || (state == SHOW && adv)) begin
            state <= SHOW;
            stored <= src;
            disp_idx <= nidx;
            disp_byte <= src[{~nidx, 3'b111} -: 8];
        end
    end
    assign have_result = (state == SHOW);
endmodule

// File: tb/tb_aes_result_led_pager.sv
// tb_aes_result_led_pager: randomized bench against a behavioural pager model
module tb_aes_result_led_pager;
    localparam int N = 4;
    localparam int S = 8;
    localparam logic [127:0] V = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] W = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    logic clk = 1'b0, rst_n = 1'b0, result_valid = 1'b0, btn_next = 1'b0, auto_scroll = 1'b0;
    logic [127:0] result = '0;
    logic [7:0] disp_byte;
    logic [3:0] disp_idx;
    logic have_result;
    int checks = 0, failures = 0;
    bit m_show, m_db, m_dbd;
    logic [127:0] m_blk;
    int m_idx, m_sc;
    bit q[$];
    bit s2h[$];

    always #5 clk = ~clk;

    aes_result_led_pager #(.DEBOUNCE_CYCLES(N), .SCROLL_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .result_valid(result_valid), .result(result),
        .btn_next(btn_next), .auto_scroll(auto_scroll),
        .disp_byte(disp_byte), .disp_idx(disp_idx), .have_result(have_result)
    );

    function automatic logic [7:0] byte_of(logic [127:0] b, int i);
        return 8'(b >> (8 * (15 - i)));
    endfunction

    // model: button level is accepted once the synchronized input has disagreed with it N times in a row
    task automatic model_step();
        bit s2cur, stp, exp, flip;
        if (!rst_n) begin
            m_show = 0; m_blk = '0; m_idx = 0; m_db = 0; m_dbd = 0; m_sc = 0;
            q = {1'b0, 1'b0};
            s2h.delete();
            return;
        end
        s2cur = q[0];
        void'(q.pop_front());
        q.push_back(btn_next);
        stp = m_db && !m_dbd;
        exp = 0;
`ifdef PAGER_AUTOSCROLL_EN
        exp = m_show && auto_scroll && m_sc == S - 1;
        m_sc = (result_valid || stp || !auto_scroll || !m_show || exp) ? 0 : m_sc + 1;
`endif
        m_dbd = m_db;
        s2h.push_back(s2cur);
        flip = s2h.size() >= N;
        for (int i = 1; i <= N && flip; i++) if (s2h[s2h.size() - i] == m_db) flip = 0;
        if (flip) m_db = !m_db;
        if (s2h.size() > 32) void'(s2h.pop_front());
        if (result_valid) begin
            m_show = 1; m_blk = result; m_idx = 0;
        end else if (m_show && (stp || exp)) m_idx = (m_idx + 1) % 16;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // one clock: advance the model with the pre-edge inputs, then compare at the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("have_result", have_result, m_show);
        chk("disp_idx", disp_idx, m_idx);
        chk("disp_byte", disp_byte, m_show ? byte_of(m_blk, m_idx) : 8'h00);
    endtask

    task automatic press(int hold, int rel);
        btn_next = 1'b1;
        repeat (hold) cycle();
        btn_next = 1'b0;
        repeat (rel) cycle();
    endtask

    initial begin
        repeat (2) cycle();
        chk("rst_byte", disp_byte, 8'h00);
        chk("rst_idx", disp_idx, 4'd0);
        chk("rst_have", have_result, 1'b0);
        rst_n = 1'b1;
        cycle();
        press(10, 10);
        chk("empty_idx", disp_idx, 4'd0);
        chk("empty_byte", disp_byte, 8'h00);
        chk("empty_have", have_result, 1'b0);
        result = V; result_valid = 1'b1;
        cycle();
        result_valid = 1'b0;
        chk("latch_byte", disp_byte, 8'h69);
        chk("latch_idx", disp_idx, 4'd0);
        chk("latch_have", have_result, 1'b1);
        btn_next = 1'b1;
        cycle();
        repeat (5) cycle();
        chk("pre_step_idx", disp_idx, 4'd0);
        cycle();
        chk("step_idx", disp_idx, 4'd1);
        chk("step_byte", disp_byte, 8'hc4);
        repeat (13) cycle();
        btn_next = 1'b0;
        repeat (10) cycle();
        chk("held_idx", disp_idx, 4'd1);
        repeat (15) press(8, 8);
        chk("wrap_idx", disp_idx, 4'd0);
        chk("wrap_byte", disp_byte, 8'h69);
        press(3, 8);
        repeat (4) press(1, 1);
        repeat (8) cycle();
        chk("glitch_idx", disp_idx, 4'd0);
        repeat (5) press(8, 8);
        chk("idx5", disp_idx, 4'd5);
        chk("idx5_byte", disp_byte, 8'h7b);
        btn_next = 1'b1;
        cycle();
        repeat (5) cycle();
        result = W; result_valid = 1'b1;
        cycle();
        result_valid = 1'b0;
        chk("race_idx", disp_idx, 4'd0);
        chk("race_byte", disp_byte, 8'h3a);
        btn_next = 1'b0;
        repeat (10) cycle();
        chk("race_after_idx", disp_idx, 4'd0);
        for (int s = 0; s < 400; s++) begin
            btn_next = 1'($urandom_range(1, 0));
            auto_scroll = 1'($urandom_range(1, 0));
            repeat ($urandom_range(12, 1)) begin
                result_valid = ($urandom_range(40, 0) == 0);
                result = {$urandom, $urandom, $urandom, $urandom};
                cycle();
            end
        end
        result_valid = 1'b0; btn_next = 1'b0; auto_scroll = 1'b0;
        repeat (10) cycle();
`ifdef PAGER_AUTOSCROLL_EN
        auto_scroll = 1'b1; result = V; result_valid = 1'b1;
        cycle();
        result_valid = 1'b0;
        repeat (8) cycle();
        chk("scroll1_idx", disp_idx, 4'd1);
        chk("scroll1_byte", disp_byte, 8'hc4);
        repeat (8) cycle();
        chk("scroll2_idx", disp_idx, 4'd2);
        chk("scroll2_byte", disp_byte, 8'he0);
        repeat (3) cycle();
        rst_n = 1'b0;
        cycle();
        chk("scroll_rst_byte", disp_byte, 8'h00);
        chk("scroll_rst_idx", disp_idx, 4'd0);
        chk("scroll_rst_have", have_result, 1'b0);
        rst_n = 1'b1; auto_scroll = 1'b0;
        repeat (4) cycle();
`endif
        result = W; result_valid = 1'b1;
        cycle();
        result_valid = 1'b0;
        press(8, 2);
        btn_next = 1'b1;
        repeat (3) cycle();
        rst_n = 1'b0;
        cycle();
        chk("midrst_byte", disp_byte, 8'h00);
        chk("midrst_idx", disp_idx, 4'd0);
        chk("midrst_have", have_result, 1'b0);
        rst_n = 1'b1; btn_next = 1'b0;
        repeat (10) cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_result_led_pager.md
Name: aes_result_led_pager

Overview:
- Reader-side companion to the compact AES top's minimal I/O.
- Latches the 128-bit result the AES core produces and pages it out one byte at a time onto the 8 board LEDs, with a debounced push-button stepping the byte index.
- Sits between the AES core's result/valid outputs and the board LED/button pins of the compact top level, so the full ciphertext can be read on the board.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz); legal range ≥ 2.
- SCROLL_CYCLES, 50000000, cycles per byte in auto-scroll mode; used only with PAGER_AUTOSCROLL_EN.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  reset, synchronous, active-low.
- result_valid  input  1  one-cycle pulse from the AES core; result is valid in the same cycle.
- result  input  128  AES output block; byte 0 = result[127:120].
- btn_next  input  1  raw, asynchronous, bouncy button (board btnU).
- auto_scroll  input  1  level; enables auto-advance (ignored without the macro).
- disp_byte  output  8  byte currently shown; drives the LEDs.
- disp_idx  output  4  index of the byte shown, 0..15.
- have_result  output  1  high once a result has been latched since reset.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - disp_byte=0, disp_idx=0, have_result=0.
  - Stored block cleared to 0; synchronizer flops, debounce counter, debounced level and edge register cleared to 0.
  - Reset mid-operation aborts everything; there is no residual state.
- States: EMPTY, SHOW.
  - EMPTY: disp_byte=0. Button steps are ignored and disp_idx stays 0.
  - EMPTY -> SHOW on result_valid.
  - SHOW never returns to EMPTY except by reset.
- Latch:
  - On an edge where result_valid=1, the block stores result, sets disp_idx=0 and have_result=1.
  - disp_byte = result[127:120] from the next cycle. Latency is 1 cycle.
  - A new result_valid while in SHOW overwrites the stored block and resets disp_idx to 0.
- Display: disp_byte = stored[127-8*disp_idx -: 8], registered and updated in the same cycle as disp_idx.
- Synchronizer: btn_next passes through 2 flops (s1, s2) before any use.
- Debounce:
  - Counter increments on every edge where s2 != db.
  - It clears on any edge where s2 == db.
  - On an edge where s2 != db and the counter equals DEBOUNCE_CYCLES-1, db takes the value of s2 and the counter clears.
  - Counter width = $clog2(DEBOUNCE_CYCLES).
- Step: step = db & ~db_d, where db_d is db delayed 1 cycle. This gives exactly one step per accepted press. Releases and glitches shorter than DEBOUNCE_CYCLES give no step.
- Step timing:
  - With N = DEBOUNCE_CYCLES, a clean press first sampled into s1 at edge k advances disp_idx at edge k+N+2.
  - A held button gives no repeat steps.
- Increment: disp_idx = disp_idx+1 mod 16; wrap 15 -> 0.
- Simultaneous result_valid and step: result_valid wins, disp_idx=0, and the step is discarded.

Optional Feature:
- Macro: PAGER_AUTOSCROLL_EN.
- With the macro defined:
  - In SHOW with auto_scroll=1, a SCROLL_CYCLES-period counter advances disp_idx once per period, wrapping as for a step.
  - The counter clears on result_valid, on a manual step, and whenever auto_scroll=0.
  - If a manual step and scroll expiry fall in the same cycle, the index advances by 1 only.
- Without the macro: no scroll counter is synthesized, auto_scroll is unused, and behaviour is purely manual.

Test Plan:
- Reset, then result_valid with result=128'h69c4e0d86a7b0430d8cdb78070b4c55a -> 1 cycle later disp_byte=8'h69, disp_idx=0, have_result=1.
- DEBOUNCE_CYCLES=4; clean press held 20 cycles, first sampled at edge k -> disp_idx=1 and disp_byte=8'hc4 at edge k+6, with exactly one step for the whole press.
- DEBOUNCE_CYCLES=4; 16 clean presses -> disp_byte sequence 69,c4,e0,…,c5,5a, then the index wraps to 0 and shows 8'h69. A 3-cycle glitch and 1-cycle bounces produce no step.
- In EMPTY (no result yet), press the button -> disp_idx=0 and disp_byte=0. Then result_valid in the same cycle as a step at disp_idx=5 -> disp_idx=0 and the new byte 0 is shown.
- With PAGER_AUTOSCROLL_EN, SCROLL_CYCLES=8, auto_scroll=1 -> disp_idx advances every 8 cycles. Deassert rst_n mid-scroll -> all outputs 0 on the next edge.
